// File: rtl/mag_sample_scheduler.sv
// Magnetometer sample scheduler: paces driver reads, supervises them with a timeout and retry limit,
// and averages 2^AVG_LOG2 good samples per axis into a registered heading vector.
module mag_sample_scheduler #(
    parameter int SAMPLE_PERIOD  = 2_000_000,
    parameter int AVG_LOG2       = 2,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 3_000_000,
    parameter bit CAL_ON_START   = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    output logic               drv_start_read,
    output logic               drv_start_calibrate,
    input  logic               drv_busy,
    input  logic               drv_data_valid,
    input  logic               drv_calibration_done,
    input  logic               drv_error,
    input  logic signed [15:0] drv_mag_x,
    input  logic signed [15:0] drv_mag_y,
    input  logic signed [15:0] drv_mag_z,
    output logic signed [15:0] avg_x,
    output logic signed [15:0] avg_y,
    output logic signed [15:0] avg_z,
    output logic               avg_valid,
    output logic               fault,
    output logic [15:0]        sample_count,
    output logic [7:0]         err_count,
    output logic [2:0]         state_dbg
);

    localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RCNT_W = $clog2(MAX_RETRY + 2);
    localparam int ACC_W  = 16 + AVG_LOG2;
    localparam int ACNT_W = AVG_LOG2 + 1;

    localparam logic [PCNT_W-1:0] PERIOD_RELOAD = PCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [TCNT_W-1:0] TMO_LAST      = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RETRY_MAX     = RCNT_W'(MAX_RETRY);
    localparam logic [ACNT_W-1:0] ACC_LAST      = ACNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CAL         = 3'd1,
        S_WAIT_PERIOD = 3'd2,
        S_WAIT_RESULT = 3'd3,
        S_FAULT       = 3'd4
    } state_t;

    state_t                   state;
    logic [PCNT_W-1:0]        period_cnt;
    logic [TCNT_W-1:0]        tmo_cnt;
    logic [RCNT_W-1:0]        retry_cnt;
    logic [ACNT_W-1:0]        acc_cnt;
    logic signed [ACC_W-1:0]  acc_x, acc_y, acc_z;
    logic signed [ACC_W-1:0]  acc_x_nxt, acc_y_nxt, acc_z_nxt;
    logic                     start_rd;
    logic                     rd_fail;

    assign state_dbg = state;

    assign acc_x_nxt = acc_x + ACC_W'(drv_mag_x);
    assign acc_y_nxt = acc_y + ACC_W'(drv_mag_y);
    assign acc_z_nxt = acc_z + ACC_W'(drv_mag_z);

    // Driver protocol: a one-cycle start pulse opens a transaction; it closes on a data_valid pulse
    // (success unless drv_error is high in that cycle), drv_error alone, or the timeout. Only one
    // transaction is ever outstanding, and a new read is issued only while drv_busy is low.
    assign rd_fail = drv_error || (!drv_data_valid && (tmo_cnt == TMO_LAST));

    // A completed calibration issues its first read directly, without a detour through S_WAIT_PERIOD.
    always_comb begin
        start_rd = 1'b0;
        if (enable && !drv_busy && (period_cnt == '0))
            start_rd = (state == S_WAIT_PERIOD) || ((state == S_CAL) && drv_calibration_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            period_cnt          <= '0;
            tmo_cnt             <= '0;
            retry_cnt           <= '0;
            acc_cnt             <= '0;
            acc_x               <= '0;
            acc_y               <= '0;
            acc_z               <= '0;
            drv_start_read      <= 1'b0;
            drv_start_calibrate <= 1'b0;
            avg_x               <= '0;
            avg_y               <= '0;
            avg_z               <= '0;
            avg_valid           <= 1'b0;
            fault               <= 1'b0;
            sample_count        <= '0;
            err_count           <= '0;
        end else begin
            drv_start_read      <= 1'b0;
            drv_start_calibrate <= 1'b0;
            avg_valid           <= 1'b0;
            if (period_cnt != '0)
                period_cnt <= period_cnt - PCNT_W'(1);

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        period_cnt <= '0;
                        if (CAL_ON_START) begin
                            drv_start_calibrate <= 1'b1;
                            tmo_cnt             <= '0;
                            state               <= S_CAL;
                        end else begin
                            state <= S_WAIT_PERIOD;
                        end
                    end
                end

                S_CAL: begin
                    tmo_cnt <= tmo_cnt + TCNT_W'(1);
                    if (drv_calibration_done) begin
                        state <= S_WAIT_PERIOD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end
                end

                S_WAIT_PERIOD: begin
                    if (!enable) begin
                        acc_cnt <= '0;
                        acc_x   <= '0;
                        acc_y   <= '0;
                        acc_z   <= '0;
                        state   <= S_IDLE;
                    end
                end

                S_WAIT_RESULT: begin
                    tmo_cnt <= tmo_cnt + TCNT_W'(1);
                    if (rd_fail) begin
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + RCNT_W'(1);
                            state     <= S_WAIT_PERIOD;
                        end else begin
                            fault <= 1'b1;
                            state <= S_FAULT;
                        end
                    end else if (drv_data_valid) begin
                        sample_count <= sample_count + 16'd1;
                        retry_cnt    <= '0;
                        state        <= S_WAIT_PERIOD;
                        if (acc_cnt == ACC_LAST) begin
                            avg_x     <= 16'(acc_x_nxt >>> AVG_LOG2);
                            avg_y     <= 16'(acc_y_nxt >>> AVG_LOG2);
                            avg_z     <= 16'(acc_z_nxt >>> AVG_LOG2);
                            avg_valid <= 1'b1;
                            acc_cnt   <= '0;
                            acc_x     <= '0;
                            acc_y     <= '0;
                            acc_z     <= '0;
                        end else begin
                            acc_cnt <= acc_cnt + ACNT_W'(1);
                            acc_x   <= acc_x_nxt;
                            acc_y   <= acc_y_nxt;
                            acc_z   <= acc_z_nxt;
                        end
                    end
                end

                S_FAULT: begin
                    if (!enable) begin
                        fault     <= 1'b0;
                        retry_cnt <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            if (start_rd) begin
                drv_start_read <= 1'b1;
                period_cnt     <= PERIOD_RELOAD;
                tmo_cnt        <= '0;
                state          <= S_WAIT_RESULT;
            end
        end
    end

endmodule

// File: tb/tb_mag_sample_scheduler.sv
// Directed bench for mag_sample_scheduler: instance A without start-up calibration, instance B with it,
// each driven by a small behavioural driver model.
module tb_mag_sample_scheduler;

    localparam int SAMPLE_PERIOD  = 100;
    localparam int AVG_LOG2       = 2;
    localparam int MAX_RETRY      = 2;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int RESP_DELAY     = 20;
    localparam int CAL_DELAY      = 10;

    localparam logic [1:0] M_DATA = 2'd0;
    localparam logic [1:0] M_ERR  = 2'd1;
    localparam logic [1:0] M_NONE = 2'd2;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_CAL         = 3'd1;
    localparam logic [2:0] ST_WAIT_RESULT = 3'd3;
    localparam logic [2:0] ST_FAULT       = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A (no calibration) ----------------
    logic               a_enable = 1'b0;
    logic               a_start_read, a_start_cal;
    logic               a_busy = 1'b0, a_valid = 1'b0, a_cal_done = 1'b0, a_error = 1'b0;
    logic signed [15:0] a_mag_x = '0, a_mag_y = '0, a_mag_z = '0;
    logic signed [15:0] a_avg_x, a_avg_y, a_avg_z;
    logic               a_avg_valid, a_fault;
    logic [15:0]        a_sample_count;
    logic [7:0]         a_err_count;
    logic [2:0]         a_state;

    mag_sample_scheduler #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD), .AVG_LOG2(AVG_LOG2), .MAX_RETRY(MAX_RETRY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CAL_ON_START(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(a_enable),
        .drv_start_read(a_start_read), .drv_start_calibrate(a_start_cal),
        .drv_busy(a_busy), .drv_data_valid(a_valid), .drv_calibration_done(a_cal_done),
        .drv_error(a_error), .drv_mag_x(a_mag_x), .drv_mag_y(a_mag_y), .drv_mag_z(a_mag_z),
        .avg_x(a_avg_x), .avg_y(a_avg_y), .avg_z(a_avg_z), .avg_valid(a_avg_valid),
        .fault(a_fault), .sample_count(a_sample_count), .err_count(a_err_count),
        .state_dbg(a_state)
    );

    // ---------------- instance B (calibration on start) ----------------
    logic               b_enable = 1'b0;
    logic               b_start_read, b_start_cal;
    logic               b_busy = 1'b0, b_valid = 1'b0, b_cal_done = 1'b0, b_error = 1'b0;
    logic signed [15:0] b_mag_x = '0, b_mag_y = '0, b_mag_z = '0;
    logic signed [15:0] b_avg_x, b_avg_y, b_avg_z;
    logic               b_avg_valid, b_fault;
    logic [15:0]        b_sample_count;
    logic [7:0]         b_err_count;
    logic [2:0]         b_state;

    mag_sample_scheduler #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD), .AVG_LOG2(AVG_LOG2), .MAX_RETRY(MAX_RETRY),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CAL_ON_START(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(b_enable),
        .drv_start_read(b_start_read), .drv_start_calibrate(b_start_cal),
        .drv_busy(b_busy), .drv_data_valid(b_valid), .drv_calibration_done(b_cal_done),
        .drv_error(b_error), .drv_mag_x(b_mag_x), .drv_mag_y(b_mag_y), .drv_mag_z(b_mag_z),
        .avg_x(b_avg_x), .avg_y(b_avg_y), .avg_z(b_avg_z), .avg_valid(b_avg_valid),
        .fault(b_fault), .sample_count(b_sample_count), .err_count(b_err_count),
        .state_dbg(b_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [47:0] exp_q[$];
    logic [47:0] samp_q[$];
    logic [1:0]  mode_q[$];

    int   a_rd_pulses = 0, a_cal_pulses = 0, prev_rd = 0;
    bit   spacing_en = 1'b0, have_prev = 1'b0;
    int   b_rd_pulses = 0, b_cal_pulses = 0, b_first_rd = 0, b_done_cyc = 0;
    bit   b_cal_ok = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic push_sample(input int x, input int y, input int z);
        samp_q.push_back({16'(x), 16'(y), 16'(z)});
    endtask

    task automatic push_exp(input int x, input int y, input int z);
        exp_q.push_back({16'(x), 16'(y), 16'(z)});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        a_enable = 1'b0;
        b_enable = 1'b0;
        rst      = 1'b1;
        cycles(30);
        mode_q.delete();
        samp_q.delete();
        exp_q.delete();
        have_prev   = 1'b0;
        a_rd_pulses = 0;
        b_rd_pulses = 0;
        b_cal_pulses = 0;
        rst = 1'b0;
        cycles(2);
    endtask

    // ---------------- driver model A ----------------
    initial begin : model_a
        logic [1:0]  m;
        logic [47:0] s;
        forever begin
            @(negedge clk);
            if (a_start_read) begin
                a_busy = 1'b1;
                m = (mode_q.size() > 0) ? mode_q.pop_front() : M_DATA;
                repeat (RESP_DELAY) @(negedge clk);
                if (m == M_DATA) begin
                    s = (samp_q.size() > 0) ? samp_q.pop_front() : '0;
                    {a_mag_x, a_mag_y, a_mag_z} = s;
                    a_valid = 1'b1;
                end else if (m == M_ERR) begin
                    {a_mag_x, a_mag_y, a_mag_z} = {3{16'h7FFF}};
                    a_valid = 1'b1;
                    a_error = 1'b1;
                end
                @(negedge clk);
                a_valid = 1'b0;
                a_error = 1'b0;
                a_busy  = 1'b0;
            end
        end
    end

    // ---------------- driver model B ----------------
    initial begin : model_b
        forever begin
            @(negedge clk);
            b_cal_done = 1'b0;
            if (b_start_cal) begin
                b_busy = 1'b1;
                repeat (CAL_DELAY) @(negedge clk);
                if (b_cal_ok) begin
                    b_cal_done = 1'b1;
                    b_done_cyc = cyc;
                end
                b_busy = 1'b0;
            end else if (b_start_read) begin
                b_busy = 1'b1;
                repeat (RESP_DELAY) @(negedge clk);
                b_valid = 1'b1;
                @(negedge clk);
                b_valid = 1'b0;
                b_busy  = 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk) begin : mon_a
        logic [47:0] e;
        if (a_start_read) begin
            if (spacing_en && have_prev)
                check("read_spacing", cyc - prev_rd, SAMPLE_PERIOD);
            prev_rd     = cyc;
            have_prev   = 1'b1;
            a_rd_pulses = a_rd_pulses + 1;
        end
        if (a_start_cal)
            a_cal_pulses = a_cal_pulses + 1;
        if (a_avg_valid) begin
            if (exp_q.size() == 0) begin
                check("avg_unexpected", a_avg_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("avg_x", sx(a_avg_x), sx(e[47:32]));
                check("avg_y", sx(a_avg_y), sx(e[31:16]));
                check("avg_z", sx(a_avg_z), sx(e[15:0]));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        if (b_start_read) begin
            if (b_rd_pulses == 0)
                b_first_rd = cyc;
            b_rd_pulses = b_rd_pulses + 1;
        end
        if (b_start_cal) begin
            b_cal_pulses = b_cal_pulses + 1;
            check("pulse_excl", b_start_read, 0);
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        cycles(5);
        check("rst_avg_x", sx(a_avg_x), 0);
        check("rst_avg_y", sx(a_avg_y), 0);
        check("rst_avg_z", sx(a_avg_z), 0);
        check("rst_avg_valid", a_avg_valid, 0);
        check("rst_fault", a_fault, 0);
        check("rst_sample_count", a_sample_count, 0);
        check("rst_err_count", a_err_count, 0);
        check("rst_start_read", a_start_read, 0);
        check("rst_start_cal", a_start_cal, 0);
        check("rst_state", a_state, ST_IDLE);
        check("rst_b_fault", b_fault, 0);
        check("rst_b_start_cal", b_start_cal, 0);
        rst = 1'b0;
        cycles(5);
        check("idle_no_read", a_rd_pulses, 0);

        // T1: rate and basic average (101 >>> 2 = 25)
        push_sample(10, 100, -100);
        push_sample(20, 200, -100);
        push_sample(30, 300, -100);
        push_sample(41, 400, -100);
        push_exp(25, 250, -100);
        spacing_en = 1'b1;
        a_enable   = 1'b1;
        cycles(350);
        spacing_en = 1'b0;
        check("t1_reads", a_rd_pulses, 4);
        check("t1_sample_count", a_sample_count, 4);
        check("t1_err_count", a_err_count, 0);
        check("t1_avg_done", exp_q.size(), 0);
        do_reset();

        // T2: negative samples floor toward -inf
        push_sample(-1, -4, 3);
        push_sample(-2, -4, -3);
        push_sample(-2, -4, 1);
        push_sample(-2, -5, -2);
        push_exp(-2, -5, -1);
        a_enable = 1'b1;
        cycles(350);
        check("t2_sample_count", a_sample_count, 4);
        check("t2_avg_done", exp_q.size(), 0);
        check("t2_avg_x_hold", sx(a_avg_x), sx(16'hFFFE));
        do_reset();

        // T3: two errored reads between good ones
        mode_q.push_back(M_DATA);
        mode_q.push_back(M_ERR);
        mode_q.push_back(M_ERR);
        push_sample(4, -8, 1);
        push_sample(8, -8, 1);
        push_sample(12, -8, 1);
        push_sample(16, -8, 2);
        push_exp(10, -8, 1);
        a_enable = 1'b1;
        cycles(250);
        check("t3_mid_err_count", a_err_count, 2);
        check("t3_mid_retry", dut_a.retry_cnt, 2);
        check("t3_mid_samples", a_sample_count, 1);
        check("t3_mid_fault", a_fault, 0);
        cycles(310);
        check("t3_err_count", a_err_count, 2);
        check("t3_retry_clear", dut_a.retry_cnt, 0);
        check("t3_fault", a_fault, 0);
        check("t3_sample_count", a_sample_count, 4);
        check("t3_reads", a_rd_pulses, 6);
        check("t3_avg_done", exp_q.size(), 0);
        do_reset();

        // T4: driver never answers -> fault on the third timeout
        repeat (6) mode_q.push_back(M_NONE);
        a_enable = 1'b1;
        cycles(200);
        check("t4_mid_fault", a_fault, 0);
        check("t4_mid_err_count", a_err_count, 2);
        cycles(300);
        check("t4_fault", a_fault, 1);
        check("t4_err_count", a_err_count, 3);
        check("t4_reads", a_rd_pulses, 3);
        check("t4_state", a_state, ST_FAULT);
        a_enable = 1'b0;
        cycles(2);
        check("t4_fault_clear", a_fault, 0);
        check("t4_state_idle", a_state, ST_IDLE);
        check("t4_err_kept", a_err_count, 3);
        do_reset();

        // T5: disable mid-read, then restart with a fresh accumulator
        push_sample(1000, 1000, 1000);
        push_sample(100, -100, 7);
        push_sample(104, -100, 7);
        push_sample(100, -100, 7);
        push_sample(100, -100, 7);
        push_exp(101, -100, 7);
        a_enable = 1'b1;
        cycles(10);
        check("t5_in_read", a_state, ST_WAIT_RESULT);
        a_enable = 1'b0;
        cycles(190);
        check("t5_reads_off", a_rd_pulses, 1);
        check("t5_samples_off", a_sample_count, 1);
        check("t5_state_off", a_state, ST_IDLE);
        check("t5_avg_pending", exp_q.size(), 1);
        a_enable = 1'b1;
        cycles(350);
        check("t5_reads", a_rd_pulses, 5);
        check("t5_sample_count", a_sample_count, 5);
        check("t5_avg_done", exp_q.size(), 0);
        check("a_no_cal", a_cal_pulses, 0);
        do_reset();

        // T6: calibration on start, then missing calibration_done
        b_cal_ok = 1'b1;
        b_enable = 1'b1;
        cycles(60);
        check("t6_cal_pulses", b_cal_pulses, 1);
        check("t6_first_read", b_rd_pulses, 1);
        check("t6_cal_to_read", b_first_rd - b_done_cyc, 1);
        check("t6_fault", b_fault, 0);
        cycles(250);
        check("t6_cal_once", b_cal_pulses, 1);
        do_reset();
        b_cal_ok = 1'b0;
        b_enable = 1'b1;
        cycles(50);
        check("t6_cal_wait", b_state, ST_CAL);
        check("t6_no_fault_yet", b_fault, 0);
        cycles(1);
        check("t6_cal_fault", b_fault, 1);
        cycles(10);
        check("t6_cal_fault_state", b_state, ST_FAULT);
        check("t6_cal_no_read", b_rd_pulses, 0);
        b_enable = 1'b0;
        cycles(2);
        check("t6_fault_clear", b_fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
